// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning chain: FSM state encoding
// and the default 100 MHz timing constants used by every button instance.
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_DB   = 3'd1,
        HELD       = 3'd2,
        REPEAT     = 3'd3,
        RELEASE_DB = 3'd4
    } btn_state_t;

    localparam int unsigned DEF_DB_CYCLES     = 1000000;   // 10 ms
    localparam int unsigned DEF_REPEAT_DELAY  = 50000000;  // 500 ms
    localparam int unsigned DEF_REPEAT_PERIOD = 10000000;  // 100 ms

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs (buttons, switches).
// Both stages clear to 0 on a synchronous active-low reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchronizes a raw pin, debounces press and release,
// and emits a one-cycle pulse per accepted press plus optional auto-repeat pulses.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
    parameter bit          REPEAT_EN     = 1'b1,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic out,
    output logic level
);

    localparam int unsigned CNT_MAX = max3(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam int          CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic             s2;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             level_q, level_d;
    logic             pulse;

    sync_2ff #(
        .WIDTH(1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (in),
        .q_o  (s2)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            level_q <= level_d;
        end
    end

    // A change on s2 is tested before any terminal count so it always wins.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s2) begin
                    state_d = PRESS_DB;
                    cnt_d   = '0;
                end
            end
            PRESS_DB: begin
                if (!s2) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    pulse   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!s2) begin
                    state_d = RELEASE_DB;
                    cnt_d   = '0;
                end else if (REPEAT_EN && (cnt_q == DELAY_LAST)) begin
                    state_d = REPEAT;
                    cnt_d   = '0;
                    pulse   = 1'b1;
                end else if (cnt_q != DELAY_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REPEAT: begin
                if (!s2) begin
                    state_d = RELEASE_DB;
                    cnt_d   = '0;
                end else if (cnt_q == PERIOD_LAST) begin
                    cnt_d = '0;
                    pulse = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE_DB: begin
                if (s2) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
        // Back-to-back pulses (only possible with a 1-cycle delay/period) are merged.
        out_d = pulse & ~out_q;
    end

    assign out   = out_q;
    assign level = level_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomized + directed bench for btn_conditioner against a run-length based
// reference model; one instance with auto-repeat, one without.
module tb_btn_conditioner;
    import btn_pkg::*;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn = 1'b0;
    logic out_r, level_r, out_n, level_n;

    always #5 clk = ~clk;

    btn_conditioner #(
        .DB_CYCLES(DB), .REPEAT_EN(1'b1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in(btn), .out(out_r), .level(level_r)
    );

    btn_conditioner #(
        .DB_CYCLES(DB), .REPEAT_EN(1'b0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_nr (
        .clk(clk), .rst_n(rst_n), .in(btn), .out(out_n), .level(level_n)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Reference model: the FSM sees the pin two edges late; a level change needs a
    // run of DB+1 identical samples; repeats are timed from the last (re)entry to held.
    logic p1, p2, run_val;
    int   run_len;
    logic m_level [2];
    int   m_age   [2];
    logic m_pulse [2];

    task automatic model_edge(input logic in_v, input logic rst_v);
        logic s, pul;
        if (!rst_v) begin
            p1 = 0; p2 = 0; run_val = 0; run_len = 0;
            for (int i = 0; i < 2; i++) begin
                m_level[i] = 0; m_age[i] = 0; m_pulse[i] = 0;
            end
            return;
        end
        s  = p2;
        p2 = p1;
        p1 = in_v;
        if (s == run_val) run_len++;
        else begin
            run_val = s;
            run_len = 1;
        end
        for (int i = 0; i < 2; i++) begin
            pul = 0;
            if (!m_level[i]) begin
                if (s && run_len == DB + 1) begin
                    m_level[i] = 1; pul = 1; m_age[i] = 0;
                end
            end else if (!s) begin
                if (run_len == DB + 1) m_level[i] = 0;
            end else if (run_len == 1) begin
                m_age[i] = 0;
            end else begin
                m_age[i]++;
                if (i == 0 && m_age[i] >= RD && ((m_age[i] - RD) % RP) == 0) pul = 1;
            end
            m_pulse[i] = pul && !m_pulse[i];
        end
    endtask

    int   e, pcount, pcount_nr, first_e, second_e, fall_e, nr_lvl_cnt;
    logic lvl_seen, lvl_drop, prev_lvl;

    task automatic new_scn();
        e = 0; pcount = 0; pcount_nr = 0; first_e = -1; second_e = -1;
        fall_e = -1; nr_lvl_cnt = 0; lvl_seen = 0; lvl_drop = 0; prev_lvl = level_r;
    endtask

    task automatic step(input logic in_v, input logic rst_v);
        btn   = in_v;
        rst_n = rst_v;
        @(posedge clk);
        model_edge(in_v, rst_v);
        @(negedge clk);
        check("out_rep", 32'(out_r), 32'(m_pulse[0]));
        check("lvl_rep", 32'(level_r), 32'(m_level[0]));
        check("out_norep", 32'(out_n), 32'(m_pulse[1]));
        check("lvl_norep", 32'(level_n), 32'(m_level[1]));
        if (out_r) begin
            pcount++;
            if (first_e < 0) first_e = e;
            else if (second_e < 0) second_e = e;
        end
        if (out_n) pcount_nr++;
        if (level_n) nr_lvl_cnt++;
        if (level_r) lvl_seen = 1;
        if (prev_lvl && !level_r) begin
            lvl_drop = 1;
            fall_e   = e;
        end
        prev_lvl = level_r;
        e++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b1);
    endtask

    initial begin
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        check("rst_out", 32'(out_r), 32'd0);
        check("rst_lvl", 32'(level_r), 32'd0);
        idle(4);

        // 1: clean press
        new_scn();
        repeat (8) step(1'b1, 1'b1);
        idle(10);
        check("s1_pulses", 32'(pcount), 32'd1);
        check("s1_edge", 32'(first_e), 32'(DB + 2));
        check("s1_fall", 32'(fall_e), 32'(8 + DB + 2));
        $display("scenario clean_press: pulses=%0d first_edge=%0d fall_edge=%0d", pcount, first_e, fall_e);

        // 2: bounce reject
        new_scn();
        step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1);
        idle(10);
        check("s2_pulses", 32'(pcount), 32'd0);
        check("s2_level", 32'(lvl_seen), 32'd0);
        check("s2_idle", 32'(dut.state_q), 32'(IDLE));
        $display("scenario bounce_reject: pulses=%0d level_seen=%0d", pcount, lvl_seen);

        // 3: release bounce restarts the repeat delay
        new_scn();
        repeat (8) step(1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b1);
        repeat (20) step(1'b1, 1'b1);
        check("s3_lvl_drop", 32'(lvl_drop), 32'd0);
        check("s3_first", 32'(first_e), 32'(DB + 2));
        check("s3_repeat", 32'(second_e), 32'd22);
        check("s3_pulses", 32'(pcount), 32'd4);
        idle(12);
        $display("scenario release_bounce: pulses=%0d first_repeat_edge=%0d", pcount, second_e);

        // 4 + 5: 40-cycle hold, with and without auto-repeat
        new_scn();
        repeat (40) step(1'b1, 1'b1);
        idle(12);
        check("s4_pulses", 32'(pcount), 32'd10);
        check("s4_repeat", 32'(second_e), 32'(DB + 2 + RD));
        check("s5_pulses", 32'(pcount_nr), 32'd1);
        check("s5_lvl_cycles", 32'(nr_lvl_cnt), 32'd40);
        $display("scenario hold40: pulses_rep=%0d pulses_norep=%0d norep_level_cycles=%0d",
                 pcount, pcount_nr, nr_lvl_cnt);

        // 6: reset while repeating
        new_scn();
        repeat (20) step(1'b1, 1'b1);
        check("s6_pre", 32'(dut.state_q), 32'(REPEAT));
        step(1'b1, 1'b0);
        check("s6_state", 32'(dut.state_q), 32'(IDLE));
        check("s6_out", 32'(out_r), 32'd0);
        check("s6_lvl", 32'(level_r), 32'd0);
        first_e = -1; pcount = 0;
        repeat (12) step(1'b1, 1'b1);
        check("s6_fresh", 32'(first_e), 32'(21 + DB + 2));
        check("s6_pulses", 32'(pcount), 32'd1);
        idle(12);
        $display("scenario reset_mid_repeat: fresh_pulse_edge=%0d", first_e);

        // Random segments with occasional reset
        new_scn();
        for (int seg = 0; seg < 200; seg++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 30))
                                              : int'($urandom_range(1, 6));
            for (int k = 0; k < len; k++)
                step(v, ($urandom_range(0, 199) != 0));
        end
        idle(12);
        $display("scenario random: cycles=%0d pulses_rep=%0d pulses_norep=%0d", e, pcount, pcount_nr);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
